// File: rtl/pixel_serializer.sv
// Batch-to-stream pixel serializer: captures NUM_ENGINES pixels at once and emits
// them one per handshake, tagging start-of-frame, end-of-line and frame completion.
module pixel_serializer #(
    parameter int RBG_SIZE     = 24,
    parameter int NUM_ENGINES  = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RBG_SIZE-1:0] rgb_in [NUM_ENGINES],
    input  logic                in_valid,
    output logic                in_ready,
    output logic [RBG_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sof,
    output logic                out_eol,
    output logic                frame_done
);

    localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int X_W   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int Y_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_HEIGHT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [RBG_SIZE-1:0] batch_q [NUM_ENGINES];
    logic [RBG_SIZE-1:0] batch_d [NUM_ENGINES];
    logic [RBG_SIZE-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sof_q, out_sof_d;
    logic                out_eol_q, out_eol_d;
    logic                frame_done_q, frame_done_d;
    logic                ready_en_q;

    logic                accept;
    logic                handshake;
    logic                last_pixel;

    assign last_pixel = (idx_q == IDX_LAST);
    assign handshake  = out_valid_q && out_ready;

    // ready_en_q holds in_ready low during reset and releases it on the first edge after.
    assign in_ready = ready_en_q &&
                      ((state_q == IDLE) || (state_q == SEND && last_pixel && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        batch_d = batch_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                    batch_d = rgb_in;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_pixel) begin
                        idx_d = '0;
                        if (accept) begin
                            batch_d = rgb_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (handshake) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Outputs are registered from the next-cycle state so they line up with state_q.
    always_comb begin
        out_valid_d  = (state_d == SEND);
        out_data_d   = out_valid_d ? batch_d[idx_d] : '0;
        out_sof_d    = out_valid_d && (x_d == '0) && (y_d == '0);
        out_eol_d    = out_valid_d && (x_d == X_LAST);
        frame_done_d = handshake && (x_q == X_LAST) && (y_q == Y_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            frame_done_q <= frame_done_d;
            ready_en_q   <= 1'b1;
        end
    end

    // NOTE: the batch store is data only and is never read while IDLE, so it carries no reset.
    always_ff @(posedge clk) begin
        batch_q <= batch_d;
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer on a 16x2 frame with 8-pixel batches.
module tb_pixel_serializer;

    localparam int RBG  = 24;
    localparam int NENG = 8;

    logic            clk;
    logic            rst_n;
    logic [RBG-1:0]  rgb_in [NENG];
    logic            in_valid;
    logic            in_ready;
    logic [RBG-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sof;
    logic            out_eol;
    logic            frame_done;

    int total;
    int bad;

    pixel_serializer #(
        .RBG_SIZE    (RBG),
        .NUM_ENGINES (NENG),
        .IMAGE_WIDTH (16),
        .IMAGE_HEIGHT(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rgb_in    (rgb_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           iv;
        logic           ordy;
        logic [RBG-1:0] base;
        logic           e_ov;
        logic           e_ir;
        logic           e_sof;
        logic           e_eol;
        logic [RBG-1:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_batch(input logic [RBG-1:0] base);
        for (int i = 0; i < NENG; i++) rgb_in[i] = base + RBG'(i);
    endtask

    task automatic add(input logic iv, input logic ordy, input logic [RBG-1:0] base,
                       input logic e_ov, input logic e_ir, input logic e_sof,
                       input logic e_eol, input logic [RBG-1:0] e_data);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.base = base;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_sof = e_sof; v.e_eol = e_eol; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_batch('0);

        // Single batch 1..8 at full rate: frame positions 0..7.
        add(1, 1, 24'h000001, 0, 1, 0, 0, 24'h0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 24'h0, 1, (k == 8), (k == 1), 0, RBG'(k));
        add(0, 1, 24'h0, 0, 1, 0, 0, 24'h0);
        // Backpressure 1,0,0,1 on batch 0x10..0x17: positions 8..15, eol on the last.
        add(1, 1, 24'h000010, 0, 1, 0, 0, 24'h0);
        add(0, 1, 24'h0, 1, 0, 0, 0, 24'h000010);
        add(0, 0, 24'h0, 1, 0, 0, 0, 24'h000011);
        add(0, 0, 24'h0, 1, 0, 0, 0, 24'h000011);
        add(0, 1, 24'h0, 1, 0, 0, 0, 24'h000011);
        for (int k = 2; k <= 7; k++)
            add(0, 1, 24'h0, 1, (k == 7), 0, (k == 7), 24'h000010 + RBG'(k));
        add(0, 1, 24'h0, 0, 1, 0, 0, 24'h0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_ir", in_ready, 1'b0);
        check("rst_sof", out_sof, 1'b0);
        check("rst_eol", out_eol, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        check("rst_data", out_data, 24'h0);
        rst_n = 1'b1;
        #1;
        check("ir_before_edge", in_ready, 1'b0);
        tick();
        check("ir_after_edge", in_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            set_batch(vecs[i].base);
            #1;
            check($sformatf("row%0d_ov", i), out_valid, vecs[i].e_ov);
            check($sformatf("row%0d_ir", i), in_ready, vecs[i].e_ir);
            check($sformatf("row%0d_sof", i), out_sof, vecs[i].e_sof);
            check($sformatf("row%0d_eol", i), out_eol, vecs[i].e_eol);
            check($sformatf("row%0d_fd", i), frame_done, 1'b0);
            if (vecs[i].e_ov) check($sformatf("row%0d_data", i), out_data, vecs[i].e_data);
            tick();
        end

        // Back-to-back batches 0x20.. and 0x28..: positions 16..31, ends the frame.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_batch(24'h000020);
        #1;
        check("b2b_ir_first", in_ready, 1'b1);
        tick();
        set_batch(24'hBAD000);
        for (int k = 0; k < 16; k++) begin
            if (k == 7) set_batch(24'h000028);
            if (k == 8) in_valid = 1'b0;
            #1;
            check($sformatf("b2b%0d_ov", k), out_valid, 1'b1);
            check($sformatf("b2b%0d_data", k), out_data, 24'h000020 + RBG'(k));
            check($sformatf("b2b%0d_sof", k), out_sof, 1'b0);
            check($sformatf("b2b%0d_eol", k), out_eol, (k == 15));
            check($sformatf("b2b%0d_fd", k), frame_done, 1'b0);
            if (k == 7) check("b2b_ir_on_8th", in_ready, 1'b1);
            tick();
        end
        #1;
        check("fd_pulse", frame_done, 1'b1);
        check("fd_ov_idle", out_valid, 1'b0);
        tick();
        check("fd_one_cycle", frame_done, 1'b0);

        // New frame starts with sof; reset after 3 pixels then restart.
        in_valid = 1'b1;
        set_batch(24'h000030);
        #1;
        check("f2_ir", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("f2_%0d_data", k), out_data, 24'h000030 + RBG'(k));
            check($sformatf("f2_%0d_sof", k), out_sof, (k == 0));
            tick();
        end
        check("pre_rst_data", out_data, 24'h000033);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", out_valid, 1'b0);
        check("mid_rst_ir", in_ready, 1'b0);
        check("mid_rst_data", out_data, 24'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ir", in_ready, 1'b1);
        check("post_rst_ov", out_valid, 1'b0);
        in_valid = 1'b1;
        set_batch(24'h000040);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rs%0d_ov", k), out_valid, 1'b1);
            check($sformatf("rs%0d_data", k), out_data, 24'h000040 + RBG'(k));
            check($sformatf("rs%0d_sof", k), out_sof, (k == 0));
            check($sformatf("rs%0d_eol", k), out_eol, 1'b0);
            tick();
        end
        check("rs_end_ov", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
